// File: rtl/mac_pkg.sv
// Shared constants and types for the mac_shift multiply-accumulate stage.
//   DATA_W/ACC_W/OUT_W : operand, accumulator and LUT-input widths
//   MAX_TERMS          : longest frame that is not flagged as overflow
//   OUT_MAX/OUT_MIN    : saturation limits of the 21-bit signed output
//   state_t            : frame control FSM states
package mac_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ACC_W     = 40;
    localparam int unsigned OUT_W     = 21;
    localparam int unsigned MAX_TERMS = 256;

    // Term counter holds 0..MAX_TERMS+1; it saturates one above the limit.
    localparam int unsigned CNT_W = $clog2(MAX_TERMS + 2);

    localparam logic [OUT_W-1:0] OUT_MAX = 21'h0FFFFF;
    localparam logic [OUT_W-1:0] OUT_MIN = 21'h100000;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift of the accumulator followed by
// saturation into the signed OUT_W result format.
//   acc_in : signed ACC_W accumulator value
//   shift  : right-shift amount (floor toward minus infinity)
//   res    : shifted, saturated OUT_W result
//   ovf    : shifted value did not fit OUT_W
module sat_shift
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [4:0]       shift,
    output logic [OUT_W-1:0] res,
    output logic             ovf
);

    // Saturation limits sign-extended to accumulator width.
    localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'(signed'(OUT_MAX));
    localparam logic signed [ACC_W-1:0] R_MIN = ACC_W'(signed'(OUT_MIN));

    logic signed [ACC_W-1:0] r;

    always_comb begin
        r   = $signed(acc_in) >>> shift;
        res = r[OUT_W-1:0];
        ovf = 1'b0;
        if (r > R_MAX) begin
            res = OUT_MAX;
            ovf = 1'b1;
        end else if (r < R_MIN) begin
            res = OUT_MIN;
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/mac_shift.sv
// Signed multiply-accumulate over a framed stream of data/weight pairs.
// At end of frame the sum is shifted and saturated into the LUT input format.
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   valid_in    : operand pair present; first_in/last_in tag frame bounds
//   data_in     : signed operand; weight_in : signed operand
//   shift_amt   : right shift for the frame (taken with the first term)
//   bypass_in   : bypass request for the frame (taken with the first term)
//   acc_out     : shifted, saturated frame result
//   shift_overf : result saturated, or frame exceeded MAX_TERMS
//   bypass_out  : bypass_in of the delivered frame
//   lut_en      : one-cycle pulse, outputs above are new
//   frame_err   : sticky protocol-error flag
module mac_shift
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              first_in,
    input  logic              last_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic [4:0]        shift_amt,
    input  logic              bypass_in,
    output logic [OUT_W-1:0]  acc_out,
    output logic              shift_overf,
    output logic              bypass_out,
    output logic              lut_en,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_TERMS);

    state_t state, state_nxt;
    logic   take;
    logic   err_set;

    // Frame control: decides which terms enter the pipeline.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        err_set   = 1'b0;
        if (valid_in) begin
            if (first_in) begin
                // A first term in ACCUM discards the open frame and restarts.
                take      = 1'b1;
                err_set   = (state == ACCUM);
                state_nxt = last_in ? IDLE : ACCUM;
            end else if (state == ACCUM) begin
                take = 1'b1;
                if (last_in) state_nxt = IDLE;
            end else begin
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_set) frame_err <= 1'b1;
        end
    end

    // S1: product and tags.
    logic                       s1_vld, s1_first, s1_last, s1_byp;
    logic [4:0]                 s1_shift;
    logic signed [2*DATA_W-1:0] s1_prod;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_byp   <= 1'b0;
            s1_shift <= '0;
            s1_prod  <= '0;
        end else begin
            s1_vld   <= take;
            s1_first <= first_in;
            s1_last  <= last_in;
            s1_byp   <= bypass_in;
            s1_shift <= shift_amt;
            s1_prod  <= $signed(data_in) * $signed(weight_in);
        end
    end

    // S2: accumulate and count terms.
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [4:0]              s2_shift;
    logic                    s2_byp, s2_fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            cnt      <= '0;
            s2_shift <= '0;
            s2_byp   <= 1'b0;
            s2_fire  <= 1'b0;
        end else begin
            s2_fire <= s1_vld & s1_last;
            if (s1_vld) begin
                if (s1_first) begin
                    acc      <= ACC_W'(s1_prod);
                    cnt      <= CNT_W'(1);
                    s2_shift <= s1_shift;
                    s2_byp   <= s1_byp;
                end else begin
                    acc <= acc + ACC_W'(s1_prod);
                    if (cnt <= CNT_LIM) cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // S3: snapshot the finished frame so the next frame may load acc
    // immediately, then shift/saturate into the output registers.
    logic [ACC_W-1:0] s3_acc;
    logic [4:0]       s3_shift;
    logic             s3_byp, s3_over, s3_fire;
    logic [OUT_W-1:0] sat_res;
    logic             sat_ovf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s3_acc   <= '0;
            s3_shift <= '0;
            s3_byp   <= 1'b0;
            s3_over  <= 1'b0;
            s3_fire  <= 1'b0;
        end else begin
            s3_fire <= s2_fire;
            if (s2_fire) begin
                s3_acc   <= acc;
                s3_shift <= s2_shift;
                s3_byp   <= s2_byp;
                s3_over  <= (cnt > CNT_LIM);
            end
        end
    end

    sat_shift u_sat_shift (
        .acc_in (s3_acc),
        .shift  (s3_shift),
        .res    (sat_res),
        .ovf    (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_out     <= '0;
            shift_overf <= 1'b0;
            bypass_out  <= 1'b0;
            lut_en      <= 1'b0;
        end else begin
            lut_en <= s3_fire;
            if (s3_fire) begin
                acc_out     <= sat_res;
                shift_overf <= sat_ovf | s3_over;
                bypass_out  <= s3_byp;
            end
        end
    end

endmodule

// File: tb/tb_mac_shift.sv
// Self-checking bench for mac_shift: a frame model pushes expected results
// (value, overflow, bypass, delivery cycle) and a monitor pops on lut_en.
module tb_mac_shift;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0, first_in = 1'b0, last_in = 1'b0;
    logic [15:0] data_in = '0, weight_in = '0;
    logic [4:0]  shift_amt = '0;
    logic        bypass_in = 1'b0;
    logic [20:0] acc_out;
    logic        shift_overf, bypass_out, lut_en, frame_err;

    mac_shift dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .first_in    (first_in),
        .last_in     (last_in),
        .data_in     (data_in),
        .weight_in   (weight_in),
        .shift_amt   (shift_amt),
        .bypass_in   (bypass_in),
        .acc_out     (acc_out),
        .shift_overf (shift_overf),
        .bypass_out  (bypass_out),
        .lut_en      (lut_en),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [20:0] acc;
        logic        ovf;
        logic        byp;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Frame model state.
    bit     m_in  = 1'b0;
    longint m_sum = 0;
    int     m_cnt = 0;
    int     m_sh  = 0;
    bit     m_b   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input longint sum, input int cnt, input int sh, input bit b, input int c);
        exp_t   e;
        longint r;
        r = sum >>> sh;
        if (r > 64'sd1048575) begin
            e.acc = 21'h0FFFFF;
            e.ovf = 1'b1;
        end else if (r < -64'sd1048576) begin
            e.acc = 21'h100000;
            e.ovf = 1'b1;
        end else begin
            e.acc = r[20:0];
            e.ovf = 1'b0;
        end
        if (cnt > 256) e.ovf = 1'b1;
        e.byp = b;
        e.cyc = c;
        return e;
    endfunction

    // Drive one term for one clock edge and update the model.
    task automatic term(input bit f, input bit l, input int d, input int w,
                        input int sh = 0, input bit b = 1'b0);
        bit acc_ok;
        valid_in  = 1'b1;
        first_in  = f;
        last_in   = l;
        data_in   = d[15:0];
        weight_in = w[15:0];
        shift_amt = sh[4:0];
        bypass_in = b;
        acc_ok    = f || m_in;
        if (f) begin
            m_in  = 1'b1;
            m_sum = longint'(d) * longint'(w);
            m_cnt = 1;
            m_sh  = sh;
            m_b   = b;
        end else if (m_in) begin
            m_sum += longint'(d) * longint'(w);
            m_cnt++;
        end
        if (acc_ok && l) begin
            sb.push_back(mk(m_sum, m_cnt, m_sh, m_b, cyc + 4));
            m_in = 1'b0;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        first_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        m_in = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acc"}, 64'(acc_out), 64'h0);
        chk({tag, "_ovf"}, 64'(shift_overf), 64'h0);
        chk({tag, "_byp"}, 64'(bypass_out), 64'h0);
        chk({tag, "_en"}, 64'(lut_en), 64'h0);
        chk({tag, "_err"}, 64'(frame_err), 64'h0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (lut_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL unexpected_lut_en: got lut_en=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lut_cycle", 64'(cyc), 64'(e.cyc));
                chk("acc_out", 64'(acc_out), 64'(e.acc));
                chk("shift_overf", 64'(shift_overf), 64'(e.ovf));
                chk("bypass_out", 64'(bypass_out), 64'(e.byp));
            end
        end
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b1;
        idle(1);

        // 4 terms of 100*3, shift 0 -> 0x4B0
        for (int i = 0; i < 4; i++) term(i == 0, i == 3, 100, 3);
        idle(2);

        // Single-term negatives, floor on shift
        term(1, 1, -5, 7, 0);
        idle(1);
        term(1, 1, -5, 7, 2);
        idle(1);

        // Positive saturation and fit after shift
        term(1, 1, 32767, 32767, 0);
        term(1, 1, 32767, 32767, 10);
        // Negative saturation
        term(1, 1, -32768, 32767, 0);
        idle(2);

        // Back-to-back single-term frames, alternating bypass
        for (int i = 0; i < 5; i++) term(1, 1, i + 1, -(i * 37 + 2), i % 3, (i % 2) == 0);
        idle(6);
        chk("no_err_yet", 64'(frame_err), 64'h0);

        // Valid without first in IDLE is dropped
        term(0, 1, 9, 9);
        idle(5);
        chk("drop_err", 64'(frame_err), 64'h1);

        // Frame with idle gaps; shift taken from first term only
        term(1, 0, 10, 10, 1);
        idle(2);
        term(0, 0, -3, 4, 7);
        term(0, 1, 1000, -1000, 9, 1'b1);
        idle(6);

        // Restart mid-frame
        do_reset();
        chk("err_cleared", 64'(frame_err), 64'h0);
        term(1, 0, 50, 50);
        term(0, 0, 7, 7);
        term(1, 0, 2, 3, 0, 1'b1);
        term(0, 1, 4, 5);
        idle(6);
        chk("restart_err", 64'(frame_err), 64'h1);

        // Reset mid-frame: no delivery, outputs cleared
        term(1, 0, 123, 45, 2, 1'b1);
        term(0, 0, 67, 89);
        do_reset();
        chk_zero("midreset");
        idle(6);
        chk_zero("midreset_after");
        term(1, 0, -100, 200, 3, 1'b1);
        term(0, 0, 300, 7);
        term(0, 1, -9, -9);
        idle(6);

        // Term-count boundary: 256 fits, 257 overflows
        for (int i = 0; i < 256; i++) term(i == 0, i == 255, 1, 1);
        for (int i = 0; i < 257; i++) term(i == 0, i == 256, 1, 1);

        // Drain with bounded wait
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
